base_ram_ctrl: RTL and testbench
================================

BASE_RAM_CTRL -- requirements
Module: base_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter UART_STROBE, default 2, number of cycles uart_rdn/uart_wrn are held low.
REQ-003 SHALL have a single clock and a synchronous, active-high reset on the ports below:
- clk  in  1  system clock (clk_50M domain)
- rst  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch read request
- if_addr  in  ADDR_W  fetch word address
- if_rdata  out  32  fetch read data
- if_ack  out  1  fetch completion pulse
- mem_req  in  1  data-port request
- mem_we  in  1  1 = write, 0 = read
- mem_uart  in  1  1 = UART space, 0 = SRAM
- mem_be  in  4  byte enables, active high
- mem_addr  in  ADDR_W  word address; bit 0 selects UART data (0) or status (1)
- mem_wdata  in  32  write data
- mem_rdata  out  32  data-port read data
- mem_ack  out  1  data-port completion pulse
- ram_addr  out  ADDR_W  SRAM address
- ram_data_o  out  32  bus drive value
- ram_data_oe  out  1  bus drive enable
- ram_data_i  in  32  bus sample value
- ram_be_n / ram_ce_n / ram_oe_n / ram_we_n  out  4/1/1/1  SRAM strobes, active low
- uart_rdn / uart_wrn  out  1/1  CPLD UART strobes, active low
- uart_dataready / uart_tbre / uart_tsre  in  1/1/1  CPLD UART status

Function
REQ-004 SHALL implement the FSM states IDLE, SRD0, SRD1, SWR0, SWR1, SWR2, URD, UWR, UWR_H and ACK.
REQ-005 In IDLE, the block SHALL grant a request and latch the port, address, be, wdata and we; mem_req SHALL have priority over if_req.
REQ-006 A simultaneous request from both ports SHALL be served mem first, then if on the next IDLE cycle.
REQ-007 An SRAM read SHALL go IDLE→SRD0→SRD1→ACK with ce_n=0, oe_n=0, be_n=~be, and if_rdata or mem_rdata <= ram_data_i at the end of SRD1; if-port reads SHALL use be_n=4'b0000.
REQ-008 An SRAM write SHALL go IDLE→SWR0→SWR1→SWR2→ACK:
- ce_n=0 in all three states
- we_n=0 only in SWR1
- ram_data_oe=1 in all three states
- oe_n=1 throughout
REQ-009 A UART data read SHALL hold ce_n=1, ram_data_oe=0 and uart_rdn=0 in URD for UART_STROBE cycles, then latch mem_rdata={24'h0, ram_data_i[7:0]} and go to ACK.
REQ-010 A UART data write SHALL set ram_data_o[7:0]=wdata[7:0] with oe=1, ce_n=1, uart_wrn=0 for UART_STROBE cycles in UWR, then hold the data for one cycle in UWR_H with wrn=1, then go to ACK.
REQ-011 A UART status read SHALL go IDLE→ACK with mem_rdata={30'h0, uart_dataready, uart_tbre&uart_tsre} and no bus strobes; a status write SHALL be acknowledged with no effect.
REQ-012 In ACK, the block SHALL pulse the served port's ack for exactly 1 cycle, perform no arbitration, and return to IDLE.
REQ-013 Request-to-ack latency SHALL be: SRAM read 3 cycles, SRAM write 4, UART read UART_STROBE+1, UART write UART_STROBE+2, status 1.
REQ-014 Requesters SHALL hold req and its fields until ack; a latched request SHALL complete even if req drops early.
REQ-015 rdata SHALL be held between acks.
REQ-016 At most one of SRAM ce_n=0, uart_rdn=0 or uart_wrn=0 SHALL be active in any cycle.
REQ-017 ram_data_oe SHALL be 0 whenever ram_oe_n=0 or uart_rdn=0.
REQ-018 ram_addr SHALL wrap naturally at 2^ADDR_W, with no range check.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL enter IDLE; ce_n, oe_n, we_n, uart_rdn and uart_wrn SHALL be 1; be_n=4'hF; ram_data_oe=0; acks=0; rdata=0; ram_addr=0.
REQ-020 A reset mid-operation SHALL abort the access with no ack issued, and the strobes SHALL be inactive from the following cycle.

Verification
REQ-021 Bench SHALL cover: if_req, addr 0x00010, SRAM holds 0x8C010004 → if_ack in cycle 3, if_rdata=0x8C010004, ce_n low exactly 2 cycles.
REQ-022 Bench SHALL cover: mem write be=4'b0011, addr 0x00020, wdata 0xDEADBEEF → we_n low 1 cycle, be_n=4'b1100, the word reads back as {old[31:16], 16'hBEEF}, mem_ack in cycle 4.
REQ-023 Bench SHALL cover: if_req and mem_req raised in the same cycle → mem_ack first, if_ack exactly one IDLE cycle after the mem ACK.
REQ-024 Bench SHALL cover: UART status read with dataready=1, tbre=tsre=1 → mem_rdata=0x3 after 1 cycle; then a UART read of byte 0x32 from the CPLD → mem_rdata=0x00000032, uart_rdn low for 2 cycles, ce_n=1 throughout.
REQ-025 Bench SHALL cover: UART write of 0x33 → uart_wrn low 2 cycles, ram_data_o[7:0]=0x33 and oe=1 from the first wrn-low cycle through one cycle after wrn rises.
REQ-026 Bench SHALL cover: rst asserted in SWR1 → next cycle all strobes inactive, oe=0, no mem_ack ever issued, FSM in IDLE.

Source files
------------

// File: rtl/base_ram_ctrl.sv
// Arbitrated controller for the base SRAM and the CPLD UART behind the same data bus.
// The data port has priority over instruction fetch. Strobes are decoded from the registered state.
module base_ram_ctrl #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned UART_STROBE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_uart,
    input  logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    input  logic [31:0]       ram_data_i,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              uart_rdn,
    output logic              uart_wrn,
    input  logic              uart_dataready,
    input  logic              uart_tbre,
    input  logic              uart_tsre
);

    typedef enum logic [3:0] {
        IDLE, SRD0, SRD1, SWR0, SWR1, SWR2, URD, UWR, UWR_H, ACK
    } state_t;

    localparam int unsigned CNT_W = (UART_STROBE > 1) ? $clog2(UART_STROBE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UART_STROBE - 1);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic                sel_mem;
    logic [3:0]          be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_mem   <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nx;

            if (state == URD || state == UWR)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            if (state == IDLE) begin
                if (mem_req) begin
                    sel_mem <= 1'b1;
                    be_q    <= mem_be;
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    // Status read completes straight from IDLE, so sample it at grant.
                    if (mem_uart && mem_addr[0] && !mem_we)
                        mem_rdata <= {30'h0, uart_dataready, uart_tbre & uart_tsre};
                end else if (if_req) begin
                    sel_mem <= 1'b0;
                    be_q    <= '1;
                    addr_q  <= if_addr;
                end
            end

            if (state == SRD1) begin
                if (sel_mem)
                    mem_rdata <= ram_data_i;
                else
                    if_rdata <= ram_data_i;
            end

            if (state == URD && cnt == CNT_LAST)
                mem_rdata <= {24'h0, ram_data_i[7:0]};
        end
    end

    always_comb begin
        state_nx    = state;
        ram_addr    = addr_q;
        ram_data_o  = wdata_q;
        ram_data_oe = 1'b0;
        ram_be_n    = '1;
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        uart_rdn    = 1'b1;
        uart_wrn    = 1'b1;
        if_ack      = 1'b0;
        mem_ack     = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    if (mem_uart)
                        state_nx = mem_addr[0] ? ACK : (mem_we ? UWR : URD);
                    else
                        state_nx = mem_we ? SWR0 : SRD0;
                end else if (if_req) begin
                    state_nx = SRD0;
                end
            end
            SRD0, SRD1: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                ram_be_n = ~be_q;
                state_nx = (state == SRD0) ? SRD1 : ACK;
            end
            SWR0, SWR1, SWR2: begin
                ram_ce_n    = 1'b0;
                ram_be_n    = ~be_q;
                ram_data_oe = 1'b1;
                ram_we_n    = (state != SWR1);
                state_nx    = (state == SWR0) ? SWR1 : ((state == SWR1) ? SWR2 : ACK);
            end
            URD: begin
                uart_rdn = 1'b0;
                if (cnt == CNT_LAST)
                    state_nx = ACK;
            end
            UWR: begin
                uart_wrn    = 1'b0;
                ram_data_oe = 1'b1;
                ram_data_o  = {24'h0, wdata_q[7:0]};
                if (cnt == CNT_LAST)
                    state_nx = UWR_H;
            end
            UWR_H: begin
                ram_data_oe = 1'b1;
                ram_data_o  = {24'h0, wdata_q[7:0]};
                state_nx    = ACK;
            end
            ACK: begin
                if_ack   = !sel_mem;
                mem_ack  = sel_mem;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_base_ram_ctrl.sv
// Bench for base_ram_ctrl: SRAM/UART device models, directed vector table,
// multi-cycle corner sequences and randomized traffic against a reference model.
module tb_base_ram_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [19:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req, mem_we, mem_uart;
    logic [3:0]  mem_be;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [19:0] ram_addr;
    logic [31:0] ram_data_o, ram_data_i;
    logic        ram_data_oe;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic        uart_rdn, uart_wrn;
    logic        uart_dataready, uart_tbre, uart_tsre;

    base_ram_ctrl #(.ADDR_W(20), .UART_STROBE(S)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_uart(mem_uart), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe),
        .ram_data_i(ram_data_i), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mem, we, uart;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [7:0]  ubyte;
        logic [2:0]  ustat;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_ce, exp_we, exp_rdn, exp_wrn, exp_doe;
        logic [3:0]  exp_ben;
    } vec_t;

    typedef struct {
        int          lat, ce, we, rdn, wrn, doe, aerr, derr;
        logic [31:0] ben, ackport, ack_after, ifr, memr;
    } res_t;

    int errors = 0;
    int checks = 0;
    int viol   = 0;
    logic [7:0]  uart_byte = 8'h00;
    logic [2:0]  ustat = 3'b000;
    logic [8:0]  uart_wr_cap;
    logic [31:0] sram [1024];
    logic [31:0] ref_mem [1024];
    bit          loaded = 1'b0;
    logic [31:0] prev_if, prev_mem;

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 16) return 32'h8C010004;
        if (i == 32) return 32'h12345678;
        return (i * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    // Device side: asynchronous SRAM, CPLD UART data/status.
    assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[9:0]] :
                        (!uart_rdn ? {24'hA5A5A5, uart_byte} : 32'h5A5A0F0F);
    assign uart_dataready = ustat[2];
    assign uart_tbre      = ustat[1];
    assign uart_tsre      = ustat[0];

    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b]) sram[ram_addr[9:0]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
        end
        if (!uart_wrn) uart_wr_cap <= {ram_data_oe, ram_data_o[7:0]};
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ((int'(!ram_ce_n) + int'(!uart_rdn) + int'(!uart_wrn)) > 1) viol <= viol + 1;
            if (ram_data_oe && (!ram_oe_n || !uart_rdn)) viol <= viol + 1;
            if (if_ack && mem_ack) viol <= viol + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit m, we, u, input logic [3:0] be, input logic [19:0] a,
                                input logic [31:0] wd, input logic [7:0] ub, input logic [2:0] us,
                                input logic [31:0] er, input int lat, ce, wen, rdn, wrn, doe,
                                input logic [3:0] ben);
        vec_t v;
        v.mem = m; v.we = we; v.uart = u; v.be = be; v.addr = a; v.wdata = wd;
        v.ubyte = ub; v.ustat = us; v.exp_rdata = er; v.exp_lat = lat; v.exp_ce = ce;
        v.exp_we = wen; v.exp_rdn = rdn; v.exp_wrn = wrn; v.exp_doe = doe; v.exp_ben = ben;
        return v;
    endfunction

    // Reference: expected outcome from the access type rules and the reference memory image.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        e.exp_rdata = '0; e.exp_ce = 0; e.exp_we = 0; e.exp_rdn = 0; e.exp_wrn = 0;
        e.exp_doe = 0; e.exp_ben = 4'hF;
        if (!v.uart) begin
            e.exp_ben = v.mem ? ~v.be : 4'h0;
            if (v.we) begin
                e.exp_lat = 4; e.exp_ce = 3; e.exp_we = 1; e.exp_doe = 3;
            end else begin
                e.exp_lat = 3; e.exp_ce = 2; e.exp_rdata = ref_mem[v.addr[9:0]];
            end
        end else if (v.addr[0]) begin
            e.exp_lat = 1;
            e.exp_rdata = {30'h0, v.ustat[2], v.ustat[1] & v.ustat[0]};
        end else if (v.we) begin
            e.exp_lat = S + 2; e.exp_wrn = S; e.exp_doe = S + 1;
        end else begin
            e.exp_lat = S + 1; e.exp_rdn = S; e.exp_rdata = {24'h0, v.ubyte};
        end
        return e;
    endfunction

    task automatic do_txn(input vec_t v, output res_t r);
        bit done = 1'b0;
        r = '{lat: -1, ce: 0, we: 0, rdn: 0, wrn: 0, doe: 0, aerr: 0, derr: 0,
              ben: 32'hF, ackport: 0, ack_after: 0, ifr: 0, memr: 0};
        @(negedge clk);
        uart_byte = v.ubyte;
        ustat     = v.ustat;
        if (v.mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_uart = v.uart; mem_be = v.be;
            mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= 20 && !done; c++) begin
            @(posedge clk); #1;
            if (!ram_ce_n) begin
                r.ce++;
                r.ben = 32'(ram_be_n);
                if (ram_addr !== v.addr) r.aerr++;
            end
            if (!ram_we_n) r.we++;
            if (!uart_rdn) r.rdn++;
            if (!uart_wrn) r.wrn++;
            if (ram_data_oe) begin
                r.doe++;
                if (v.uart && ram_data_o[7:0] !== v.wdata[7:0]) r.derr++;
            end
            if (if_ack || mem_ack) begin
                r.lat = c; r.ackport = 32'(mem_ack); r.ifr = if_rdata; r.memr = mem_rdata;
                done = 1'b1;
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        @(posedge clk); #1;
        r.ack_after = 32'(if_ack | mem_ack);
    endtask

    task automatic apply(input string tag, input vec_t v);
        res_t r;
        do_txn(v, r);
        chk({tag, "_latency"}, r.lat, v.exp_lat);
        chk({tag, "_ackport"}, r.ackport, 32'(v.mem));
        chk({tag, "_ackwidth"}, r.ack_after, 0);
        chk({tag, "_ce_cycles"}, r.ce, v.exp_ce);
        chk({tag, "_we_cycles"}, r.we, v.exp_we);
        chk({tag, "_rdn_cycles"}, r.rdn, v.exp_rdn);
        chk({tag, "_wrn_cycles"}, r.wrn, v.exp_wrn);
        chk({tag, "_doe_cycles"}, r.doe, v.exp_doe);
        chk({tag, "_be_n"}, r.ben, 32'(v.exp_ben));
        chk({tag, "_addr_err"}, r.aerr, 0);
        chk({tag, "_uart_data_err"}, r.derr, 0);
        if (v.mem && v.uart && v.we && !v.addr[0])
            chk({tag, "_uart_byte"}, 32'(uart_wr_cap), {23'h0, 1'b1, v.wdata[7:0]});
        if (!v.we) begin
            if (v.mem) prev_mem = v.exp_rdata;
            else       prev_if  = v.exp_rdata;
        end
        chk({tag, "_if_rdata"}, r.ifr, prev_if);
        chk({tag, "_mem_rdata"}, r.memr, prev_mem);
        if (v.mem && v.we && !v.uart)
            for (int b = 0; b < 4; b++)
                if (v.be[b]) ref_mem[v.addr[9:0]][b*8 +: 8] = v.wdata[b*8 +: 8];
    endtask

    vec_t tbl [9];

    initial begin
        int mem_at, if_at, mem_n, if_n, late_acks;
        bit hit;

        tbl[0] = mk(0,0,0,4'hF,20'h00010,32'h0,8'h00,3'b000,32'h8C010004,3,2,0,0,0,0,4'h0);
        tbl[1] = mk(1,1,0,4'b0011,20'h00020,32'hDEADBEEF,8'h00,3'b000,32'h0,4,3,1,0,0,3,4'b1100);
        tbl[2] = mk(1,0,0,4'hF,20'h00020,32'h0,8'h00,3'b000,32'h1234BEEF,3,2,0,0,0,0,4'h0);
        tbl[3] = mk(1,0,1,4'hF,20'h00001,32'h0,8'h00,3'b111,32'h00000003,1,0,0,0,0,0,4'hF);
        tbl[4] = mk(1,0,1,4'hF,20'h00000,32'h0,8'h32,3'b000,32'h00000032,3,0,0,2,0,0,4'hF);
        tbl[5] = mk(1,1,1,4'hF,20'h00000,32'hFFFFFF33,8'h00,3'b000,32'h0,4,0,0,0,2,3,4'hF);
        tbl[6] = mk(1,0,1,4'hF,20'h00001,32'h0,8'h00,3'b110,32'h00000002,1,0,0,0,0,0,4'hF);
        tbl[7] = mk(1,1,1,4'hF,20'h00001,32'h12345678,8'h00,3'b111,32'h0,1,0,0,0,0,0,4'hF);
        tbl[8] = mk(1,0,0,4'b0101,20'h00010,32'h0,8'h00,3'b000,32'h8C010004,3,2,0,0,0,0,4'b1010);

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_uart = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}), 32'h1F);
        chk("reset_be_n", 32'(ram_be_n), 32'hF);
        chk("reset_oe_acks", 32'({ram_data_oe, if_ack, mem_ack}), 0);
        chk("reset_rdata", if_rdata | mem_rdata, 0);
        chk("reset_addr", 32'(ram_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_if = '0;
        prev_mem = '0;

        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Both ports in the same cycle: data port first, fetch after one IDLE cycle.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_uart = 1'b0; mem_be = 4'hF;
        mem_addr = 20'h00030; mem_wdata = 32'hCAFEF00D;
        if_req = 1'b1; if_addr = 20'h00010;
        mem_at = -1; if_at = -1; mem_n = 0; if_n = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (mem_ack) begin mem_at = c; mem_n++; mem_req = 1'b0; end
            if (if_ack)  begin if_at = c; if_n++; if_req = 1'b0; end
        end
        chk("both_mem_ack_cycle", mem_at, 4);
        chk("both_if_ack_cycle", if_at, 8);
        chk("both_ack_counts", 32'({mem_n[7:0], if_n[7:0]}), 32'h0101);
        chk("both_if_rdata", if_rdata, 32'h8C010004);
        ref_mem[32'h30] = 32'hCAFEF00D;
        prev_if = 32'h8C010004;

        // Reset while the write strobe is low.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_uart = 1'b0; mem_be = 4'hF;
        mem_addr = 20'h00040; mem_wdata = 32'h0BADF00D;
        hit = 1'b0;
        for (int c = 1; c <= 10 && !hit; c++) begin
            @(posedge clk); #1;
            if (!ram_we_n) hit = 1'b1;
        end
        chk("rst_mid_reach_swr1", 32'(hit), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}), 32'h1F);
        chk("rst_mid_oe_be", 32'({ram_data_oe, ram_be_n}), 32'hF);
        chk("rst_mid_ack", 32'({if_ack, mem_ack}), 0);
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        late_acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_ack || if_ack) late_acks++;
        end
        chk("rst_mid_no_ack", late_acks, 0);
        prev_if = '0;
        prev_mem = '0;
        apply("post_rst_fetch", tbl[0]);

        for (int n = 0; n < 60; n++) begin
            vec_t v;
            int unsigned kind = $urandom_range(0, 6);
            v = mk(kind != 0, kind == 2 || kind == 4 || kind == 6, kind >= 3,
                   4'($urandom_range(1, 15)), {10'($urandom), 4'b0, 6'($urandom)},
                   $urandom, 8'($urandom), 3'($urandom), 32'h0, 0, 0, 0, 0, 0, 0, 4'hF);
            if (kind == 0) v.be = 4'hF;
            if (kind == 3 || kind == 4) v.addr[0] = 1'b0;
            if (kind >= 5) v.addr[0] = 1'b1;
            apply($sformatf("rnd%0d_k%0d", n, kind), model(v));
        end

        chk("protocol_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
